// File: rtl/dmem_store_unit_pkg.sv
// ============================================================================
// dmem_store_unit_pkg
// Shared store-select codes, FSM state encoding and request legality check
// for the data-memory store path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package dmem_store_unit_pkg;

  // Store width select as produced by the store decoder
  localparam logic [1:0] ST_SW  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SB  = 2'b10;
  localparam logic [1:0] ST_RSV = 2'b11;

  // Store FSM states, 3-bit encoding
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_MERGE = 3'd2,
    S_WR    = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  // A request is illegal when it is misaligned for its width or uses the
  // reserved select code; such requests never touch memory.
  function automatic logic req_is_bad(input logic [1:0] sel, input logic [1:0] lo);
    logic bad;
    case (sel)
      ST_SW:   bad = (lo != 2'b00);
      ST_SH:   bad = lo[0];
      ST_SB:   bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_store_unit_st_merge.sv
// ============================================================================
// dmem_store_unit_st_merge
// Combinational lane merge: replaces the addressed halfword or byte of an
// existing memory word with new store data, leaving other bytes untouched.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module dmem_store_unit_st_merge
  import dmem_store_unit_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  st_sel,
  input  logic [1:0]  byte_off,
  output logic [31:0] merged
);

  // Start from the old word and overwrite only the lane being stored
  always_comb begin
    merged = old_word;
    case (st_sel)
      ST_SH: begin
        if (byte_off[1]) merged[31:16] = new_data[15:0];
        else             merged[15:0]  = new_data[15:0];
      end
      ST_SB: begin
        case (byte_off)
          2'd0:    merged[7:0]   = new_data[7:0];
          2'd1:    merged[15:8]  = new_data[7:0];
          2'd2:    merged[23:16] = new_data[7:0];
          default: merged[31:24] = new_data[7:0];
        endcase
      end
      default: merged = new_data;  // full-word store replaces everything
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_store_unit.sv
// ============================================================================
// dmem_store_unit
// Store-path engine for a word-only DMEM without byte enables. SW writes
// directly; SH/SB perform read-modify-write. Misaligned or reserved requests
// pulse err and never access memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module dmem_store_unit
  import dmem_store_unit_pkg::*;
#(
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        st_sel,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              err
);

  state_t              state;
  state_t              state_next;
  logic [1:0]          sel_q;
  logic [MEM_AW+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         merge_q;
  logic [31:0]         merged;
  logic                accept;

  // Address bits above the DMEM range do not select anything
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:MEM_AW+2];

  assign accept    = req_valid && req_ready;
  assign req_ready = rst_n && (state == S_IDLE);
  assign mem_addr  = addr_q[MEM_AW+1:2];

  dmem_store_unit_st_merge u_merge (
    .old_word (mem_rdata),
    .new_data (wdata_q),
    .st_sel   (sel_q),
    .byte_off (addr_q[1:0]),
    .merged   (merged)
  );

  // State register; reset abandons any in-flight store
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Capture the request on transfer so later cycles are independent of req_*
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q   <= ST_SW;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      sel_q   <= st_sel;
      addr_q  <= addr[MEM_AW+1:0];
      wdata_q <= wdata;
    end
  end

  // Merge register holds the read word with the new lane substituted
  always_ff @(posedge clk) begin
    if (!rst_n)                 merge_q <= '0;
    else if (state == S_MERGE)  merge_q <= merged;
  end

  // Next-state selection
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_is_bad(st_sel, addr[1:0])) state_next = S_ERR;
          else if (st_sel == ST_SW)          state_next = S_WR;
          else                               state_next = S_RD;
        end
      end
      S_RD:    state_next = S_MERGE;
      S_MERGE: state_next = S_WR;
      S_WR:    state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Strobes decoded purely from registered state and latched request
  always_comb begin
    mem_re    = (state == S_RD);
    mem_we    = (state == S_WR);
    done      = (state == S_WR);
    err       = (state == S_ERR);
    mem_wdata = (sel_q == ST_SW) ? wdata_q : merge_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_store_unit.sv
// ============================================================================
// tb_dmem_store_unit
// Scoreboard bench: the driver pushes expected memory writes / error pulses
// computed from a byte-level reference memory; a monitor pops and compares
// whenever the DUT presents mem_we or err.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_store_unit;

  localparam int AW    = 14;
  localparam int WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    st_sel = 2'b00;
  logic [31:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic [31:0]   mem_rdata = '0;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  dmem_store_unit #(.MEM_AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .st_sel    (st_sel),
    .addr      (addr),
    .wdata     (wdata),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .done      (done),
    .err       (err)
  );

  // Memory model driven by the DUT, plus a preload port for the bench
  logic [31:0]   dmem [0:WORDS-1];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [31:0]   pre_data = '0;

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= dmem[mem_addr];
    if (mem_we) dmem[mem_addr] <= mem_wdata;
    if (pre_en) dmem[pre_addr] <= pre_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference memory and scoreboard
  logic [31:0] ref_mem [0:WORDS-1];
  typedef struct {
    bit            is_err;
    logic [AW-1:0] waddr;
    logic [31:0]   data;
    int            at;
  } exp_t;
  exp_t q[$];

  int tests = 0;
  int fails = 0;
  int reads_seen = 0;
  int reads_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: legality by size/alignment, then byte-wise replace
  task automatic push_expected(input logic [1:0] sel, input logic [31:0] a,
                               input logic [31:0] d, input int t);
    exp_t          e;
    int            size;
    int            off;
    logic [31:0]   nw;
    logic [AW-1:0] w;
    w    = a[AW+1:2];
    off  = int'(a[1:0]);
    size = (sel == 2'd0) ? 4 : (sel == 2'd1) ? 2 : 1;
    if (sel == 2'd3 || (off % size) != 0) begin
      e = '{is_err: 1'b1, waddr: w, data: 32'h0, at: t};
    end else begin
      nw = ref_mem[w];
      for (int b = 0; b < size; b++) nw[8*(off+b) +: 8] = d[8*b +: 8];
      ref_mem[w] = nw;
      e = '{is_err: 1'b0, waddr: w, data: nw, at: t + ((sel == 2'd0) ? 0 : 2)};
      if (sel != 2'd0) reads_exp++;
    end
    q.push_back(e);
  endtask

  // Monitor: compares every presented write/error against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (mem_re) reads_seen++;
      if (mem_re || mem_we || err) begin
        check1("ready_while_busy", req_ready, 1'b0);
        check1("re_we_exclusive", mem_re && mem_we, 1'b0);
      end
      if (mem_we || err) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output: we=%0b err=%0b addr=%h data=%08h", mem_we, err, mem_addr, mem_wdata);
        end else begin
          e = q.pop_front();
          check1("err_kind", err, e.is_err);
          check1("done_kind", done, !e.is_err);
          check("out_cycle", 32'(cyc), 32'(e.at));
          if (!e.is_err) begin
            check("wr_addr", 32'(mem_addr), 32'(e.waddr));
            check("wr_data", mem_wdata, e.data);
          end else begin
            check1("err_no_we", mem_we, 1'b0);
          end
        end
      end else if (q.size() > 0 && cyc > q[0].at) begin
        tests++; fails++;
        $display("FAIL missing_output: expected at cycle %0d, now %0d", q[0].at, cyc);
        void'(q.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge
  task automatic issue(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] d,
                       input bit keep_valid, output int t);
    bit ok;
    ok = 1'b0;
    t  = -1;
    req_valid = 1'b1; st_sel = sel; addr = a; wdata = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (req_ready) begin
        t = cyc + 1;
        push_expected(sel, a, d, t);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL issue_timeout: req_ready never rose");
    end
    if (!keep_valid) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || !req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL idle_timeout: queue=%0d ready=%0b", q.size(), req_ready);
    end
    @(negedge clk);
  endtask

  task automatic preload(input logic [AW-1:0] w, input logic [31:0] v);
    pre_en = 1'b1; pre_addr = w; pre_data = v;
    ref_mem[w] = v;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  logic [31:0] sb_exp [0:3];
  logic [31:0] saved;
  int t, t0, t1, t2;

  initial begin
    sb_exp[0] = 32'h112233AB; sb_exp[1] = 32'h1122AB44;
    sb_exp[2] = 32'h11AB3344; sb_exp[3] = 32'hAB223344;

    // Reset: outputs quiet and req_ready low while rst_n is low
    @(negedge clk);
    for (int i = 0; i < 16; i++) preload(AW'(i), $urandom);
    preload(AW'('h40), 32'h0);
    check1("rst_ready", req_ready, 1'b0);
    check1("rst_we", mem_we, 1'b0);
    check1("rst_re", mem_re, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_err", err, 1'b0);
    check("rst_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check1("ready_after_rst", req_ready, 1'b1);

    // SW aligned
    issue(2'd0, 32'h100, 32'hDEADBEEF, 1'b0, t);
    check1("sw_no_re", mem_re, 1'b0);
    @(negedge clk);
    check1("sw_ready_cycle2", req_ready, 1'b1);
    wait_idle();
    check("sw_mem", dmem[14'h40], 32'hDEADBEEF);

    // SB into each lane; upper wdata bits must be ignored
    for (int k = 0; k < 4; k++) begin
      preload(AW'('h10), 32'h11223344);
      issue(2'd2, 32'h40 + 32'(k), 32'h5A5A5AAB, 1'b0, t);
      wait_idle();
      check($sformatf("sb_lane%0d", k), dmem[14'h10], sb_exp[k]);
    end

    // SH both halves
    preload(AW'('h80), 32'hCAFEF00D);
    issue(2'd1, 32'h202, 32'h00001234, 1'b0, t);
    wait_idle();
    check("sh_high", dmem[14'h80], 32'h1234F00D);
    preload(AW'('h80), 32'hCAFEF00D);
    issue(2'd1, 32'h200, 32'h00001234, 1'b0, t);
    wait_idle();
    check("sh_low", dmem[14'h80], 32'hCAFE1234);

    // Misaligned / reserved: err at cycle 1, ready again at cycle 2
    issue(2'd0, 32'h101, 32'h1, 1'b0, t);
    @(negedge clk);
    check1("err_sw_ready", req_ready, 1'b1);
    issue(2'd1, 32'h203, 32'h2, 1'b0, t);
    @(negedge clk);
    check1("err_sh_ready", req_ready, 1'b1);
    issue(2'd3, 32'h300, 32'h3, 1'b0, t);
    @(negedge clk);
    check1("err_rsv_ready", req_ready, 1'b1);
    wait_idle();

    // Backpressure: three SBs with req_valid held high
    issue(2'd2, 32'h20, 32'h000000C1, 1'b1, t0);
    issue(2'd2, 32'h25, 32'h000000C2, 1'b1, t1);
    issue(2'd2, 32'h2A, 32'h000000C3, 1'b0, t2);
    check("bp_spacing1", 32'(t1 - t0), 32'd4);
    check("bp_spacing2", 32'(t2 - t1), 32'd4);
    wait_idle();

    // Reset during MERGE of an SB: no write may follow
    preload(AW'(5), 32'h0BADF00D);
    saved = ref_mem[5];
    issue(2'd2, 32'h16, 32'h000000EE, 1'b0, t);
    @(negedge clk);            // MERGE is now visible
    rst_n = 1'b0;
    @(negedge clk);
    q.delete();
    ref_mem[5] = saved;
    check1("midrst_we", mem_we, 1'b0);
    check1("midrst_ready", req_ready, 1'b0);
    check("midrst_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    check1("midrst_we2", mem_we, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_mem", dmem[5], 32'h0BADF00D);
    issue(2'd0, 32'h18, 32'h600DCAFE, 1'b0, t);
    wait_idle();
    check("post_rst_sw", dmem[6], 32'h600DCAFE);

    // Randomized mix over a small address window
    for (int n = 0; n < 200; n++) begin
      logic [1:0]  s;
      logic [31:0] a;
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) s = 2'd3;
      else if (s == 2'd3) s = 2'd2;
      a = {26'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 4'h0} >> 4;
      a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)) | (32'($urandom) & 32'hFFFF0000);
      issue(s, a, $urandom, ($urandom_range(0, 1) == 1), t);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    req_valid = 1'b0;
    wait_idle();

    check("queue_empty", 32'(q.size()), 32'd0);
    check("read_count", 32'(reads_seen), 32'(reads_exp));
    for (int i = 0; i < 16; i++) check($sformatf("final_mem%0d", i), dmem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
